// File: rtl/mpsoc_wb_gpio_arbiter.sv
// rtl/mpsoc_wb_gpio_arbiter.sv - round-robin Wishbone arbiter in front of one mpsoc_wb_gpio slave port
// Grant is held for a whole cyc; a per-grant watchdog aborts transfers the slave never terminates.
module mpsoc_wb_gpio_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 8,
    parameter int TIMEOUT       = 15
) (
    input  logic                                   wb_clk_i,
    input  logic                                   wb_rst_i,
    input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                 m_stb_i,
    input  logic [NUM_MASTERS-1:0]                 m_we_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]               m_sel_i,
    output logic [WB_DATA_WIDTH-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]                 m_ack_o,
    output logic [NUM_MASTERS-1:0]                 m_err_o,
    output logic                                   s_cyc_o,
    output logic                                   s_stb_o,
    output logic                                   s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]               s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]               s_dat_o,
    output logic [3:0]                             s_sel_o,
    input  logic [WB_DATA_WIDTH-1:0]               s_dat_i,
    input  logic                                   s_ack_i,
    input  logic                                   s_err_i,
    output logic [NUM_MASTERS-1:0]                 grant_o,
    output logic                                   busy_o
);

    localparam int OW    = $clog2(NUM_MASTERS);
    localparam int WDT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = (TIMEOUT > 0) ? WDT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [NUM_MASTERS-1:0]  grant_n;
    logic [OW-1:0]           last, last_n;
    logic [WDT_W-1:0]        wdt, wdt_n;
    logic [OW-1:0]           cand;
    logic [OW-1:0]           pick;
    logic                    found;
    logic                    own_cyc;
    logic                    stalled;

    // In OWN, last doubles as the index of the granted master.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            grant_o <= '0;
            last    <= OW'(NUM_MASTERS - 1);
            wdt     <= '0;
        end else begin
            state   <= state_n;
            grant_o <= grant_n;
            last    <= last_n;
            wdt     <= wdt_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_o;
        last_n  = last;
        wdt_n   = wdt;
        cand    = '0;
        pick    = last;
        found   = 1'b0;
        own_cyc = 1'b0;
        stalled = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;

        case (state)
            IDLE: begin
                // Search starts one past the previous owner, giving strict rotation.
                for (int i = 1; i <= NUM_MASTERS; i++) begin
                    cand = OW'((int'(last) + i) % NUM_MASTERS);
                    if (!found && m_cyc_i[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                wdt_n = '0;
                if (found) begin
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    last_n        = pick;
                    state_n       = OWN;
                end
            end

            OWN: begin
                own_cyc = m_cyc_i[last];
                s_cyc_o = own_cyc;
                s_stb_o = m_stb_i[last] & own_cyc;
                s_we_o  = m_we_i[last];
                s_adr_o = m_adr_i[last*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                s_dat_o = m_dat_i[last*WB_DATA_WIDTH +: WB_DATA_WIDTH];
                s_sel_o = m_sel_i[last*4 +: 4];
                // Terminations arriving after the owner dropped cyc are discarded.
                m_ack_o[last] = s_ack_i & own_cyc;
                m_err_o[last] = s_err_i & own_cyc;
                stalled = s_stb_o & ~s_ack_i & ~s_err_i;

                if (!own_cyc) begin
                    state_n = IDLE;
                    grant_n = '0;
                    wdt_n   = '0;
                end else if (stalled && (TIMEOUT > 0)) begin
                    if (wdt == WDT_LAST) begin
                        m_err_o[last] = 1'b1;
                        state_n       = ABORT;
                        grant_n       = '0;
                        wdt_n         = '0;
                    end else begin
                        wdt_n = wdt + 1'b1;
                    end
                end else begin
                    wdt_n = '0;
                end
            end

            ABORT: begin
                state_n = IDLE;
                grant_n = '0;
                wdt_n   = '0;
            end

            default: begin
                state_n = IDLE;
                grant_n = '0;
                wdt_n   = '0;
            end
        endcase
    end

    assign m_dat_o = s_dat_i;
    assign busy_o  = (state != IDLE);

endmodule
